time_display_encoder: RTL and testbench

- Consumer (read side) of the time-of-day counter's minutes/hours outputs.
- Periodically captures minutes/hours and rejects samples taken while the counter is mid-rollover.
- Converts both values to BCD with a sequential double-dabble.
- Drives the four on-board 7-segment displays (HH:MM) as static, registered outputs.

---
 rtl/time_display_encoder.sv | 224 ++++++++++++++++++++++
 tb/tb_time_display_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/time_display_encoder.sv
// time_display_encoder
//   Samples the time-of-day counter once per refresh tick. A sample is only used
//   once it is stable for a full cycle, and it is converted to BCD with a sequential
//   double-dabble. The result drives four static 7-segment digits showing HH:MM.
//
// Ports
//   reset         async active-high reset
//   clk_50MHz     system clock
//   minutes       signed minutes from the time counter (legal 0..59)
//   hours         signed hours from the time counter (legal 0..23)
//   hex0..hex3    minutes ones/tens, hours ones/tens; bit0 = seg a .. bit6 = seg g
//   digits_valid  displays show a converted in-range time
//   range_err     displays show dashes because the sample was out of range
//   update_done   one-cycle pulse whenever hex0..hex3 are reloaded
module time_display_encoder #(
    parameter int unsigned REFRESH_DIV        = 50000,
    parameter bit          SEG_ACTIVE_LOW     = 1'b1,
    parameter bit          BLANK_LEADING_ZERO = 1'b0
) (
    input  logic               reset,
    input  logic               clk_50MHz,
    input  logic signed [31:0] minutes,
    input  logic signed [31:0] hours,
    output logic        [6:0]  hex0,
    output logic        [6:0]  hex1,
    output logic        [6:0]  hex2,
    output logic        [6:0]  hex3,
    output logic               digits_valid,
    output logic               range_err,
    output logic               update_done
);

    localparam int unsigned    DivW     = $clog2(REFRESH_DIV);
    localparam logic [DivW-1:0] DivMax  = DivW'(REFRESH_DIV - 1);
    localparam logic [6:0]     SegPol   = {7{SEG_ACTIVE_LOW}};
    localparam logic [6:0]     SegBlank = 7'h00 ^ SegPol;
    localparam logic [6:0]     SegDash  = 7'h40 ^ SegPol;

    typedef enum logic [1:0] {StIdle, StConfirm, StConvert, StUpdate} state_e;

    // Active-high pattern for one BCD digit, {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // One double-dabble iteration on {tens, ones, binary[5:0]}
    function automatic logic [13:0] dd_step(input logic [13:0] r);
        logic [3:0] t;
        logic [3:0] o;
        t = r[13:10];
        o = r[9:6];
        if (t >= 4'd5) t = t + 4'd3;
        if (o >= 4'd5) o = o + 4'd3;
        return {t[2:0], o, r[5:0], 1'b0};
    endfunction

    state_e             state_q, state_d;
    logic [DivW-1:0]    div_q, div_d;
    logic signed [31:0] samp_min_q, samp_min_d;
    logic signed [31:0] samp_hrs_q, samp_hrs_d;
    logic [1:0]         retry_q, retry_d;
    logic [2:0]         iter_q, iter_d;
    logic [13:0]        dd_min_q, dd_min_d;
    logic [13:0]        dd_hrs_q, dd_hrs_d;
    logic [6:0]         hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
    logic               valid_q, valid_d, err_q, err_d, done_q, done_d;

    logic tick, samples_equal, in_range;
    logic capture, clr_retry, inc_retry, load_dash, load_dd, step_dd, load_digits;

    assign tick          = (div_q == DivMax);
    assign samples_equal = (minutes == samp_min_q) && (hours == samp_hrs_q);
    assign in_range      = (samp_min_q >= 0) && (samp_min_q <= 59) &&
                           (samp_hrs_q >= 0) && (samp_hrs_q <= 23);

    // FSM state register
    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (tick) state_d = StConfirm;
            StConfirm: begin
                if (samples_equal)          state_d = in_range ? StConvert : StIdle;
                else if (retry_q == 2'd2)   state_d = StIdle;  // third mismatch gives up
            end
            StConvert: if (iter_q == 3'd5) state_d = StUpdate;
            StUpdate:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM datapath strobes
    always_comb begin
        capture     = 1'b0;
        clr_retry   = 1'b0;
        inc_retry   = 1'b0;
        load_dash   = 1'b0;
        load_dd     = 1'b0;
        step_dd     = 1'b0;
        load_digits = 1'b0;
        unique case (state_q)
            StIdle: begin
                capture   = tick;
                clr_retry = tick;
            end
            StConfirm: begin
                capture   = !samples_equal;
                inc_retry = !samples_equal;
                load_dash = samples_equal && !in_range;
                load_dd   = samples_equal && in_range;
            end
            StConvert: step_dd     = 1'b1;
            StUpdate:  load_digits = 1'b1;
            default: ;
        endcase
    end

    // Datapath next state
    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        samp_min_d = capture ? minutes : samp_min_q;
        samp_hrs_d = capture ? hours   : samp_hrs_q;
        retry_d    = retry_q;
        if (clr_retry)      retry_d = 2'd0;
        else if (inc_retry) retry_d = retry_q + 2'd1;
        iter_d   = iter_q;
        dd_min_d = dd_min_q;
        dd_hrs_d = dd_hrs_q;
        if (load_dd) begin
            iter_d   = 3'd0;
            dd_min_d = {8'd0, samp_min_q[5:0]};
            dd_hrs_d = {8'd0, samp_hrs_q[5:0]};
        end else if (step_dd) begin
            iter_d   = iter_q + 3'd1;
            dd_min_d = dd_step(dd_min_q);
            dd_hrs_d = dd_step(dd_hrs_q);
        end
        hex0_d  = hex0_q;
        hex1_d  = hex1_q;
        hex2_d  = hex2_q;
        hex3_d  = hex3_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = load_dash || load_digits;
        if (load_dash) begin
            hex0_d  = SegDash;
            hex1_d  = SegDash;
            hex2_d  = SegDash;
            hex3_d  = SegDash;
            valid_d = 1'b0;
            err_d   = 1'b1;
        end else if (load_digits) begin
            hex0_d  = seg_encode(dd_min_q[9:6])   ^ SegPol;
            hex1_d  = seg_encode(dd_min_q[13:10]) ^ SegPol;
            hex2_d  = seg_encode(dd_hrs_q[9:6])   ^ SegPol;
            hex3_d  = (BLANK_LEADING_ZERO && dd_hrs_q[13:10] == 4'd0) ? SegBlank :
                      seg_encode(dd_hrs_q[13:10]) ^ SegPol;
            valid_d = 1'b1;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            samp_min_q <= '0;
            samp_hrs_q <= '0;
            retry_q    <= 2'd0;
            iter_q     <= 3'd0;
            dd_min_q   <= '0;
            dd_hrs_q   <= '0;
            hex0_q     <= SegBlank;
            hex1_q     <= SegBlank;
            hex2_q     <= SegBlank;
            hex3_q     <= SegBlank;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            samp_min_q <= samp_min_d;
            samp_hrs_q <= samp_hrs_d;
            retry_q    <= retry_d;
            iter_q     <= iter_d;
            dd_min_q   <= dd_min_d;
            dd_hrs_q   <= dd_hrs_d;
            hex0_q     <= hex0_d;
            hex1_q     <= hex1_d;
            hex2_q     <= hex2_d;
            hex3_q     <= hex3_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign hex0         = hex0_q;
    assign hex1         = hex1_q;
    assign hex2         = hex2_q;
    assign hex3         = hex3_q;
    assign digits_valid = valid_q;
    assign range_err    = err_q;
    assign update_done  = done_q;

endmodule

// File: tb/tb_time_display_encoder.sv
module tb_time_display_encoder;

    logic               clk_50MHz = 1'b0;
    logic               reset = 1'b0;
    logic signed [31:0] minutes = 32'sd7;
    logic signed [31:0] hours = 32'sd13;

    logic [6:0] hex0, hex1, hex2, hex3;
    logic       digits_valid, range_err, update_done;
    logic [6:0] hex0_b, hex1_b, hex2_b, hex3_b;
    logic       digits_valid_b, range_err_b, update_done_b;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk_50MHz = ~clk_50MHz;

    time_display_encoder #(.REFRESH_DIV(16), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) dut (
        .reset(reset), .clk_50MHz(clk_50MHz), .minutes(minutes), .hours(hours),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .digits_valid(digits_valid), .range_err(range_err), .update_done(update_done)
    );

    time_display_encoder #(.REFRESH_DIV(16), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b1)) dut_b (
        .reset(reset), .clk_50MHz(clk_50MHz), .minutes(minutes), .hours(hours),
        .hex0(hex0_b), .hex1(hex1_b), .hex2(hex2_b), .hex3(hex3_b),
        .digits_valid(digits_valid_b), .range_err(range_err_b), .update_done(update_done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    function automatic logic [6:0] seg_lo(input int d);
        return ~seg_tab[d];
    endfunction

    int         mdiv, ms_m, ms_h, mretry, mcnt;
    bit         mbusy, mwait;
    logic [6:0] e_hex0, e_hex1, e_hex2, e_hex3, e_hex3b;
    bit         e_dv, e_re, e_upd;

    always @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            mdiv = 0; mbusy = 0; mwait = 0; mretry = 0; mcnt = 0;
            e_hex0 = 7'h7F; e_hex1 = 7'h7F; e_hex2 = 7'h7F; e_hex3 = 7'h7F; e_hex3b = 7'h7F;
            e_dv = 0; e_re = 0; e_upd = 0;
        end else begin
            bit tk;
            tk    = (mdiv == 15);
            mdiv  = tk ? 0 : mdiv + 1;
            e_upd = 0;
            if (!mbusy) begin
                if (tk) begin
                    ms_m = minutes; ms_h = hours; mretry = 0; mbusy = 1; mwait = 0;
                end
            end else if (!mwait) begin
                if (minutes == ms_m && hours == ms_h) begin
                    if (ms_m < 0 || ms_m > 59 || ms_h < 0 || ms_h > 23) begin
                        e_hex0 = 7'h3F; e_hex1 = 7'h3F; e_hex2 = 7'h3F;
                        e_hex3 = 7'h3F; e_hex3b = 7'h3F;
                        e_re = 1; e_dv = 0; e_upd = 1; mbusy = 0;
                    end else begin
                        mwait = 1;
                        mcnt  = 7;  // six conversion steps plus the load
                    end
                end else begin
                    ms_m = minutes; ms_h = hours; mretry++;
                    if (mretry == 3) mbusy = 0;
                end
            end else begin
                mcnt--;
                if (mcnt == 0) begin
                    e_hex0  = seg_lo(ms_m % 10);
                    e_hex1  = seg_lo(ms_m / 10);
                    e_hex2  = seg_lo(ms_h % 10);
                    e_hex3  = seg_lo(ms_h / 10);
                    e_hex3b = (ms_h / 10 == 0) ? 7'h7F : seg_lo(ms_h / 10);
                    e_dv = 1; e_re = 0; e_upd = 1; mbusy = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk_50MHz) begin
        if (chk_en) begin
            chk("m_hex0", hex0, e_hex0);
            chk("m_hex1", hex1, e_hex1);
            chk("m_hex2", hex2, e_hex2);
            chk("m_hex3", hex3, e_hex3);
            chk("m_valid", digits_valid, e_dv);
            chk("m_err", range_err, e_re);
            chk("m_done", update_done, e_upd);
            chk("mb_hex0", hex0_b, e_hex0);
            chk("mb_hex1", hex1_b, e_hex1);
            chk("mb_hex2", hex2_b, e_hex2);
            chk("mb_hex3", hex3_b, e_hex3b);
            chk("mb_valid", digits_valid_b, e_dv);
            chk("mb_err", range_err_b, e_re);
            chk("mb_done", update_done_b, e_upd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_upd(input int maxc, output int n);
        n = 0;
        do begin
            @(negedge clk_50MHz);
            n++;
        end while (!update_done && n < maxc);
        if (!update_done) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_upd: no update_done within %0d cycles, expected one", maxc);
        end
    endtask

    task automatic wait_tick_cycle();
        int k;
        k = 0;
        do begin
            @(negedge clk_50MHz);
            k++;
        end while (mdiv != 15 && k < 40);
        chk("tick_seen", 32'(mdiv), 32'd15);
    endtask

    task automatic chk_hex(input string name, input logic [6:0] a0, input logic [6:0] a1,
                           input logic [6:0] a2, input logic [6:0] a3);
        chk({name, "_hex0"}, hex0, a0);
        chk({name, "_hex1"}, hex1, a1);
        chk({name, "_hex2"}, hex2, a2);
        chk({name, "_hex3"}, hex3, a3);
    endtask

    initial begin
        int  n;
        bit  saw;
        #2 reset = 1'b1;
        chk_en = 1'b1;
        #1;
        chk_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("rst_valid", digits_valid, 1'b0);
        repeat (3) @(negedge clk_50MHz);
        reset = 1'b0;

        // First update: tick in cycle 15, loads 9 edges later
        wait_upd(40, n);
        chk("first_latency", 32'(n), 32'd24);
        chk_hex("t2", 7'h78, 7'h40, 7'h30, 7'h79);
        chk("t2_valid", digits_valid, 1'b1);
        @(negedge clk_50MHz);
        chk("t2_pulse", update_done, 1'b0);

        minutes = 59; hours = 23;
        wait_upd(40, n);
        chk_hex("t3a", 7'h10, 7'h12, 7'h30, 7'h24);
        minutes = 0; hours = 0;
        wait_upd(40, n);
        chk_hex("t3b", 7'h40, 7'h40, 7'h40, 7'h40);

        // Single glitch right after the tick costs one retry
        minutes = 59;
        wait_tick_cycle();
        @(negedge clk_50MHz);
        minutes = 0;
        wait_upd(40, n);
        chk("glitch_latency", 32'(n + 1), 32'd10);
        chk_hex("t4a", 7'h40, 7'h40, 7'h40, 7'h40);

        // Persistent toggling aborts after three retries
        wait_tick_cycle();
        minutes = 10;
        saw = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50MHz);
            minutes = (i % 2 == 0) ? 32'sd11 : 32'sd10;
            saw |= update_done;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_50MHz);
            saw |= update_done;
        end
        chk("t4b_no_update", 32'(saw), 32'd0);
        chk_hex("t4b", 7'h40, 7'h40, 7'h40, 7'h40);

        minutes = 60; hours = 5;
        wait_upd(40, n);
        chk_hex("t5a", 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        chk("t5a_err", range_err, 1'b1);
        chk("t5a_valid", digits_valid, 1'b0);
        minutes = 1;
        wait_upd(40, n);
        chk_hex("t5b", 7'h79, 7'h40, 7'h12, 7'h40);
        chk("t5b_err", range_err, 1'b0);

        // Reset in the middle of conversion
        minutes = 59; hours = 23;
        wait_tick_cycle();
        repeat (4) @(negedge clk_50MHz);
        #2 reset = 1'b1;
        #1;
        chk_hex("t6", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        chk("t6_valid", digits_valid, 1'b0);
        repeat (2) @(negedge clk_50MHz);
        reset = 1'b0;
        wait_upd(40, n);
        chk_hex("t6b", 7'h10, 7'h12, 7'h30, 7'h24);

        minutes = 30; hours = 5;
        wait_upd(40, n);
        chk("t7_b_hex3", hex3_b, 7'h7F);
        chk("t7_b_hex2", hex2_b, 7'h12);
        chk("t7_b_hex1", hex1_b, 7'h30);
        chk("t7_b_hex0", hex0_b, 7'h40);
        chk("t7_hex3", hex3, 7'h40);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
